pau_result_serializer: RTL and testbench
========================================

PAU_RESULT_SERIALIZER -- requirements
Module: pau_result_serializer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of lanes per input vector (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, operand width; lane width OUT_W = DATA_WIDTH+1.
REQ-003 SHALL have parameter SATURATE, default 0, 1 = clamp each lane to DATA_WIDTH bits on output.
REQ-004 SHALL define LANE_W = max(1, clog2(NUM_LANES)).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  input vector present.
REQ-008 in_ready  output  1  serializer accepts vector this cycle.
REQ-009 in_flat  input  NUM_LANES*OUT_W  packed lanes; lane i at bits [(i+1)*OUT_W-1 -: OUT_W].
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts beat.
REQ-012 out_data  output  OUT_W  current lane value (after optional clamp).
REQ-013 out_lane  output  LANE_W  index of current lane.
REQ-014 out_last  output  1  high on lane NUM_LANES-1 beat.
REQ-015 out_ovf  output  1  bit DATA_WIDTH of the raw current lane (carry out).
REQ-016 ovf_count  output  LANE_W+1  number of lanes with carry set in the vector being sent.

Function
REQ-017 SHALL implement FSM states IDLE and SEND.
REQ-018 IDLE: in_ready=1, out_valid=0; in_valid=1 captures in_flat into holding register, clears lane index to 0, computes ovf_count, moves to SEND next cycle.
REQ-019 SEND: out_valid=1; out_data/out_lane/out_ovf/out_last reflect holding-register lane at current index.
REQ-020 Beat transfer occurs when out_valid && out_ready; lane index increments by 1 on transfer.
REQ-021 out_valid stall (out_ready=0): out_data, out_lane, out_last, out_ovf SHALL hold stable.
REQ-022 Lanes SHALL emit in ascending order 0..NUM_LANES-1, exactly once each, no skips or repeats.
REQ-023 In SEND, in_ready SHALL be 1 only in the cycle the last beat transfers (out_last && out_ready); otherwise 0.
REQ-024 Last-beat transfer with in_valid=1: capture new vector, index to 0, remain SEND (zero-bubble back-to-back).
REQ-025 Last-beat transfer with in_valid=0: go to IDLE; out_valid=0 next cycle.
REQ-026 SATURATE=1: out_data = 2^DATA_WIDTH-1 when raw lane bit DATA_WIDTH=1, else raw; bit DATA_WIDTH of out_data always 0.
REQ-027 SATURATE=0: out_data = raw lane, unmodified.
REQ-028 out_ovf SHALL reflect raw carry independent of SATURATE.
REQ-029 ovf_count SHALL be registered at capture and held constant through the vector's beats; range 0..NUM_LANES.
REQ-030 Latency: first beat out_valid SHALL assert the cycle after acceptance; N lanes complete in minimum NUM_LANES cycles.
REQ-031 in_flat changes while not accepted SHALL not affect output.

Reset
REQ-032 rst=1 SHALL force IDLE, out_valid=0, out_lane=0, out_last=0, out_ovf=0, out_data=0, ovf_count=0, holding register=0 at next edge.
REQ-033 rst mid-vector SHALL discard remaining lanes; no beat of that vector emitted after reset deasserts.
REQ-034 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.

Verification
REQ-035 Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, ovf_count=0, in_ready=0 during, 1 after.
REQ-036 Basic: lanes {0x00001,0x00002,0x00003,0x00004}, out_ready=1 -> 4 beats in consecutive cycles, out_lane 0..3, out_last only on lane 3, ovf_count=0.
REQ-037 Backpressure: same vector, out_ready toggling 1,0,0,1,... -> each lane held stable during stalls, order 0..3, no duplicates.
REQ-038 Overflow: lanes {0x1FFFE,0x00005,0x10000,0x0FFFF}, SATURATE=1 -> out_data 0xFFFF,0x0005,0xFFFF,0xFFFF; out_ovf 1,0,1,0; ovf_count=2; SATURATE=0 -> raw values.
REQ-039 Back-to-back: second vector valid during last beat -> in_ready=1 that cycle, lane 0 of vector 2 next cycle, 8 beats in 8 cycles.
REQ-040 Mid-reset: rst pulsed after lane 1 transfer -> out_valid=0 next cycle, lanes 2-3 never emitted, next vector starts at lane 0.

Source files
------------

// File: rtl/pau_result_serializer.sv
// Result serializer: captures a vector of NUM_LANES carry-extended lanes and emits them
// one lane per beat over a valid/ready stream, with optional per-lane saturation.
module pau_result_serializer #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int SATURATE   = 0,
    localparam int OUT_W     = DATA_WIDTH + 1,
    localparam int LANE_W    = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LANES*OUT_W-1:0] in_flat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [LANE_W-1:0]          out_lane,
    output logic                       out_last,
    output logic                       out_ovf,
    output logic [LANE_W:0]            ovf_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [NUM_LANES*OUT_W-1:0] hold_q, hold_d;
    logic [LANE_W-1:0]          idx_q, idx_d;
    logic [LANE_W:0]            cnt_q, cnt_d;

    logic [LANE_W:0]            in_cnt;
    logic [OUT_W-1:0]           lane_raw;
    logic                       is_last;
    logic                       sending;

    always_comb begin
        in_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            in_cnt = in_cnt + (LANE_W+1)'(in_flat[i*OUT_W + DATA_WIDTH]);
        end
    end

    assign lane_raw = hold_q[int'(idx_q)*OUT_W +: OUT_W];
    assign is_last  = (idx_q == LANE_W'(NUM_LANES - 1));
    assign sending  = (state_q == SEND);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_d  = in_flat;
                    idx_d   = '0;
                    cnt_d   = in_cnt;
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (is_last) begin
                        // Last beat frees the holding register in the same cycle.
                        in_ready = 1'b1;
                        idx_d    = '0;
                        if (in_valid) begin
                            hold_d = in_flat;
                            cnt_d  = in_cnt;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + LANE_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    generate
        if (SATURATE != 0) begin : g_sat
            assign out_data = !sending ? '0 :
                              lane_raw[DATA_WIDTH] ? {1'b0, {DATA_WIDTH{1'b1}}} : lane_raw;
        end else begin : g_raw
            assign out_data = sending ? lane_raw : '0;
        end
    endgenerate

    assign out_lane  = idx_q;
    assign out_last  = sending && is_last;
    assign out_ovf   = sending && lane_raw[DATA_WIDTH];
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_pau_result_serializer.sv
// Bench for pau_result_serializer: raw and saturating instances share stimulus and are
// checked every cycle against a queue of expected beats.
module tb_pau_result_serializer;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int W  = DW + 1;
    localparam int LW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [N*W-1:0] in_flat;
    logic           out_ready;

    logic           in_ready_r, out_valid_r, out_last_r, out_ovf_r;
    logic [W-1:0]   out_data_r;
    logic [LW-1:0]  out_lane_r;
    logic [LW:0]    ovf_count_r;

    logic           in_ready_s, out_valid_s, out_last_s, out_ovf_s;
    logic [W-1:0]   out_data_s;
    logic [LW-1:0]  out_lane_s;
    logic [LW:0]    ovf_count_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pau_result_serializer #(.NUM_LANES(N), .DATA_WIDTH(DW), .SATURATE(0)) u_raw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_flat(in_flat),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
        .out_lane(out_lane_r), .out_last(out_last_r), .out_ovf(out_ovf_r),
        .ovf_count(ovf_count_r)
    );

    pau_result_serializer #(.NUM_LANES(N), .DATA_WIDTH(DW), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_flat(in_flat),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_lane(out_lane_s), .out_last(out_last_s), .out_ovf(out_ovf_s),
        .ovf_count(ovf_count_s)
    );

    typedef struct {
        logic [W-1:0] raw;
        int           lane;
    } beat_t;

    beat_t exp_q[$];
    int    cnt_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c, input logic [W-1:0] d);
        return {d, c, b, a};
    endfunction

    task automatic push_vec(input logic [N*W-1:0] f);
        beat_t b;
        cnt_m = 0;
        for (int i = 0; i < N; i++) begin
            b.raw  = f[i*W +: W];
            b.lane = i;
            exp_q.push_back(b);
            if (b.raw[DW]) cnt_m++;
        end
    endtask

    // One clock: drive, check at the falling edge, advance the model, take the edge.
    task automatic cycle(input logic r, input logic iv, input logic [N*W-1:0] f,
                         input logic ordy);
        logic         exp_rdy;
        logic [W-1:0] exp_sat;
        beat_t        b;
        rst = r; in_valid = iv; in_flat = f; out_ready = ordy;
        @(negedge clk);
        exp_rdy = !r && (exp_q.size() == 0 || (exp_q.size() == 1 && ordy));
        chk("in_ready", 32'(in_ready_r), 32'(exp_rdy));
        chk("in_ready_sat", 32'(in_ready_s), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid_r), 32'(exp_q.size() != 0));
        chk("out_valid_sat", 32'(out_valid_s), 32'(exp_q.size() != 0));
        chk("ovf_count", 32'(ovf_count_r), 32'(cnt_m));
        if (exp_q.size() != 0) begin
            b = exp_q[0];
            exp_sat = b.raw[DW] ? W'(17'h0FFFF) : b.raw;
            chk("out_data_raw", 32'(out_data_r), 32'(b.raw));
            chk("out_data_sat", 32'(out_data_s), 32'(exp_sat));
            chk("out_lane", 32'(out_lane_r), 32'(b.lane));
            chk("out_last", 32'(out_last_r), 32'(b.lane == N - 1));
            chk("out_ovf_raw", 32'(out_ovf_r), 32'(b.raw[DW]));
            chk("out_ovf_sat", 32'(out_ovf_s), 32'(b.raw[DW]));
        end
        if (r) begin
            exp_q.delete();
            cnt_m = 0;
        end else begin
            if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
            if (exp_rdy && iv) push_vec(f);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int pattern);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            cycle(1'b0, 1'b0, '0, (pattern == 0) ? 1'b1 : (k % 3 == 0));
        end
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [N*W-1:0] vb, vc, rf;
        logic [W-1:0]   l0, l1, l2, l3;
        vb = mk(17'h00001, 17'h00002, 17'h00003, 17'h00004);
        vc = mk(17'h1FFFE, 17'h00005, 17'h10000, 17'h0FFFF);

        rst = 1'b1; in_valid = 1'b1; in_flat = vc; out_ready = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b1, vc, 1'b1);
        cycle(1'b1, 1'b1, vc, 1'b1);
        chk("rst_out_data", 32'(out_data_r), 32'd0);
        chk("rst_out_lane", 32'(out_lane_r), 32'd0);
        chk("rst_out_last", 32'(out_last_r), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf_r), 32'd0);

        // basic stream, then backpressure on the same vector
        cycle(1'b0, 1'b1, vb, 1'b1);
        drain(0);
        cycle(1'b0, 1'b0, vc, 1'b1);
        cycle(1'b0, 1'b1, vb, 1'b0);
        drain(1);

        // overflow lanes
        cycle(1'b0, 1'b1, vc, 1'b1);
        drain(0);

        // back-to-back: second vector offered during the last beat
        cycle(1'b0, 1'b1, vb, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, vc, 1'b1);
        cycle(1'b0, 1'b1, vc, 1'b1);
        chk("b2b_pending", 32'(exp_q.size()), 32'(N));
        drain(0);

        // reset after lane 1 has transferred
        cycle(1'b0, 1'b1, vc, 1'b1);
        cycle(1'b0, 1'b0, vb, 1'b1);
        cycle(1'b0, 1'b0, vb, 1'b1);
        cycle(1'b1, 1'b0, vb, 1'b1);
        cycle(1'b0, 1'b0, vb, 1'b1);
        cycle(1'b0, 1'b1, vb, 1'b1);
        drain(0);

        // random traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            l0 = W'($urandom); l1 = W'($urandom); l2 = W'($urandom); l3 = W'($urandom);
            rf = mk(l0, l1, l2, l3);
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), rf,
                  ($urandom_range(0, 3) != 0));
        end
        drain(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
